// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the execute stage and mul_div_unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0_exc;

  modport master (output start, op, a, b, input busy, done, hi, lo, div0_exc);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div0_exc);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit writing HI/LO
// Optional MULDIV_DIV0_EXC_EN: divide by zero pulses div0_exc/done at once and leaves HI/LO alone.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  mul_div_unit_if.slave io_bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_is_div;
  logic               w_div0;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_dshift;
  logic               w_dge;
  logic [WIDTH-1:0]   w_ddiff;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = io_bus.op[0];
  assign w_is_div = io_bus.op[1];
  assign w_abs_a  = (w_signed && io_bus.a[WIDTH-1]) ? -io_bus.a : io_bus.a;
  assign w_abs_b  = (w_signed && io_bus.b[WIDTH-1]) ? -io_bus.b : io_bus.b;
  assign w_last   = (r_count == CW'(WIDTH-1));

`ifdef MULDIV_DIV0_EXC_EN
  logic r_div0;

  assign w_div0 = w_is_div && (io_bus.b == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_div0 <= 1'b0;
    else       r_div0 <= w_accept && w_div0;
  end

  assign io_bus.div0_exc = r_div0;
`else
  assign w_div0          = 1'b0;
  assign io_bus.div0_exc = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_accept = 1'b1;
          if (!w_div0) w_state_nxt = RUN;
        end
      end
      RUN:     if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiply keeps {partial product, remaining multiplier bits} in r_acc;
  // divide keeps {remainder, dividend bits shifting into quotient bits}.
  assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_dshift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_opnd});
  assign w_ddiff  = w_dshift[WIDTH-1:0] - r_opnd;
  assign w_step   = r_is_div ? (w_dge ? {w_ddiff, r_acc[WIDTH-2:0], 1'b1}
                                      : {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0})
                             : {w_madd, r_acc[WIDTH-1:1]};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_div0) begin
          r_done <= 1'b1;
        end else begin
          r_busy   <= 1'b1;
          r_count  <= '0;
          r_is_div <= w_is_div;
          r_neg_q  <= w_signed && (io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1]);
          r_neg_r  <= w_signed && w_is_div && io_bus.a[WIDTH-1];
          r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
          r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
        end
      end
      if (r_state == RUN) begin
        r_acc   <= w_step;
        r_count <= r_count + CW'(1);
      end
      if (r_state == FIX) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_hi   <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        r_lo   <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
      end
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.hi   = r_hi;
  assign io_bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] h;
  logic [31:0] l;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: p = {32'h0, a} * {32'h0, b};
      2'b01: p = sa * sb;
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          p = {a, ((sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic idle_cycles(input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("idle_no_done", cnt, 0);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a
  // following call starts in that same cycle (back-to-back).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int glitch, output logic [31:0] got_hi, output logic [31:0] got_lo);
    logic [63:0] exp;
    bit d0;
    bit seen;
    int k;
    int busy_n;
    d0 = 1'b0;
`ifdef MULDIV_DIV0_EXC_EN
    d0 = op[1] && (b == 0);
`endif
    exp = d0 ? {m_hi, m_lo} : ref_model(op, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    k      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && k <= 100) begin
      @(negedge clk);
      if (k == glitch) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        k++;
      end
    end
    bus.start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", k, d0 ? 0 : 33);
    check("busy_cycles", busy_n, d0 ? 0 : 33);
    check("busy_at_done", bus.busy, 0);
    check("div0_exc", bus.div0_exc, d0);
    check("hi", bus.hi, exp[63:32]);
    check("lo", bus.lo, exp[31:0]);
    m_hi   = exp[63:32];
    m_lo   = exp[31:0];
    got_hi = bus.hi;
    got_lo = bus.lo;
  endtask

  task automatic abort_test();
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    check("abort_div0", bus.div0_exc, 0);
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    idle_cycles(40);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_hi      = '0;
    m_lo      = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_div0", bus.div0_exc, 0);
    rst = 1'b0;
    idle_cycles(50);

    run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, -1, h, l);
    check("mult_hi", h, 32'hFFFF_FFFF);
    check("mult_lo", l, 32'hFFFF_FFFA);
    idle_cycles(2);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, h, l);
    check("multu_hi", h, 32'hFFFF_FFFE);
    check("multu_lo", l, 32'h0000_0001);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, h, l);
    check("b2b_div_hi", h, 32'hFFFF_FFFF);
    check("b2b_div_lo", l, 32'hFFFF_FFFD);
    idle_cycles(3);

    run_op(2'b10, 32'd100, 32'd7, 10, h, l);
    check("ignored_start_lo", l, 32'd14);
    check("ignored_start_hi", h, 32'd2);
    idle_cycles(2);

    run_op(2'b10, 32'h0000_2211, 32'h0000_0100, -1, h, l);
    check("preload_hi", h, 32'h11);
    check("preload_lo", l, 32'h22);
    run_op(2'b10, 32'd5, 32'd0, -1, h, l);
`ifdef MULDIV_DIV0_EXC_EN
    check("div0_hi", h, 32'h11);
    check("div0_lo", l, 32'h22);
`else
    check("div0_hi", h, 32'd5);
    check("div0_lo", l, 32'hFFFF_FFFF);
`endif
    idle_cycles(2);

    abort_test();
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, h, l);
    check("div_ovf_lo", l, 32'h8000_0000);
    check("div_ovf_hi", h, 32'h0000_0000);
    idle_cycles(1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), -1, h, l);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_cycles(gap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
